// File: rtl/xbar_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : xbar_port_sched
// Purpose  : Per-output-port round-robin scheduler for the crossbar. Grants
//            one of N requesting inputs and holds that grant for a whole
//            packet, until the last beat is accepted at the output. The
//            binary grant index drives the output data mux select.
// Ports    : clk         - clock, rising edge
//            rst         - synchronous active-high reset
//            req         - per-input request vector [N]
//            beat_fire   - output handshake completed this cycle
//            beat_last   - firing beat is the last of its packet
//            grant       - registered one-hot grant [N]
//            grant_valid - registered OR of grant
//            grant_idx   - registered binary index of the granted input
//            pkt_done    - registered one-cycle pulse after packet release
//            wdog_err    - sticky watchdog error (XBAR_SCHED_WDOG_EN only)
// Options  : XBAR_SCHED_WDOG_EN - enables the BUSY watchdog and wdog_err.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_port_sched #(
    parameter int N           = 4,
    parameter int IDXW        = $clog2(N),
    parameter int WDOG_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            beat_fire,
    input  logic            beat_last,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            pkt_done
`ifdef XBAR_SCHED_WDOG_EN
    ,
    output logic            wdog_err
`endif
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] w_ptr_nxt;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    w_grant_nxt;
    logic            r_grant_valid;
    logic            w_grant_valid_nxt;
    logic [IDXW-1:0] r_grant_idx;
    logic [IDXW-1:0] w_grant_idx_nxt;
    logic            r_pkt_done;
    logic            w_pkt_done_nxt;

    logic            w_win_found;
    logic [IDXW-1:0] w_win_idx;
    logic            w_rel_beat;
    logic            w_wdog_to;

    assign w_rel_beat = beat_fire & beat_last;

    // Round-robin search starting at r_ptr. Iterating from the farthest
    // offset down lets the nearest requester overwrite earlier hits, so no
    // early exit is needed.
    always_comb begin
        int j;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        j           = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j[IDXW-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = j[IDXW-1:0];
            end
        end
    end

`ifdef XBAR_SCHED_WDOG_EN
    localparam int                c_WDW       = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [c_WDW-1:0] c_WDOG_LAST = c_WDW'(WDOG_CYCLES - 1);

    logic [c_WDW-1:0] r_wcnt;
    logic             r_wdog_err;

    // A last beat on the timeout edge wins: that is a normal release.
    assign w_wdog_to = (r_state == c_BUSY) && (r_wcnt == c_WDOG_LAST) && !w_rel_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt     <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state == c_IDLE) begin
                r_wcnt <= '0;
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_wdog_to) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^WDOG_CYCLES;
    assign w_wdog_to     = 1'b0;
`endif

    // State register (together with the registered outputs it qualifies)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_pkt_done    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_pkt_done    <= w_pkt_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = c_BUSY;
                end
            end
            c_BUSY: begin
                if (w_rel_beat || w_wdog_to) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Next values of the registered outputs and the round-robin pointer.
    // The pointer only moves on release, so a held grant never skews it.
    always_comb begin
        w_grant_nxt       = r_grant;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_idx_nxt   = r_grant_idx;
        w_pkt_done_nxt    = 1'b0;
        w_ptr_nxt         = r_ptr;
        case (r_state)
            c_IDLE: begin
                if (w_win_found) begin
                    w_grant_nxt            = '0;
                    w_grant_nxt[w_win_idx] = 1'b1;
                    w_grant_valid_nxt      = 1'b1;
                    w_grant_idx_nxt        = w_win_idx;
                end
            end
            c_BUSY: begin
                if (w_rel_beat || w_wdog_to) begin
                    w_grant_nxt       = '0;
                    w_grant_valid_nxt = 1'b0;
                    w_grant_idx_nxt   = '0;
                    w_pkt_done_nxt    = w_rel_beat;
                    w_ptr_nxt         = (r_grant_idx == IDXW'(N - 1)) ? '0 : r_grant_idx + 1'b1;
                end
            end
            default: begin
                w_grant_nxt       = '0;
                w_grant_valid_nxt = 1'b0;
                w_grant_idx_nxt   = '0;
            end
        endcase
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign pkt_done    = r_pkt_done;

endmodule
`default_nettype wire

// File: tb/tb_xbar_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbar_port_sched
// Purpose  : Self-checking bench for xbar_port_sched. A driver applies
//            directed and random cycles, runs a behavioural model of the
//            scheduler and queues the expected outputs for each edge; a
//            monitor pops and compares them on the falling edge.
// Options  : XBAR_SCHED_WDOG_EN - also exercises the watchdog (WDOG_CYCLES=8)
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_port_sched;

    localparam int N    = 4;
    localparam int IDXW = 2;
    localparam int WD   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic            beat_fire;
    logic            beat_last;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic            pkt_done;
    logic            dut_werr;

    xbar_port_sched #(
        .N           (N),
        .IDXW        (IDXW),
        .WDOG_CYCLES (WD)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .beat_fire   (beat_fire),
        .beat_last   (beat_last),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .pkt_done    (pkt_done)
`ifdef XBAR_SCHED_WDOG_EN
        ,
        .wdog_err    (dut_werr)
`endif
    );

`ifndef XBAR_SCHED_WDOG_EN
    assign dut_werr = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        logic [N-1:0]    grant;
        logic            gv;
        logic [IDXW-1:0] idx;
        logic            done;
        logic            werr;
    } exp_t;

    exp_t expq[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Behavioural model: one packet owner at a time, pointer = one past
    // the last released owner.
    // ------------------------------------------------------------------
    bit m_busy  = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_wcnt  = 0;
    bit m_done  = 0;
    bit m_werr  = 0;

    task model_edge(input logic r, input logic [N-1:0] rq, input logic bf, input logic bl);
        if (r) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_wcnt = 0; m_done = 0; m_werr = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (rq[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_busy  = 1;
                        m_wcnt  = 0;
                        break;
                    end
                end
            end else if (bf && bl) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
                m_done = 1;
            end else begin
`ifdef XBAR_SCHED_WDOG_EN
                if (m_wcnt == WD - 1) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % N;
                    m_werr = 1;
                end else begin
                    m_wcnt = m_wcnt + 1;
                end
`endif
            end
        end
    endtask

    task step(input logic r, input logic [N-1:0] rq, input logic bf, input logic bl);
        exp_t e;
        rst       = r;
        req       = rq;
        beat_fire = bf;
        beat_last = bl;
        model_edge(r, rq, bf, bl);
        e.cyc   = cyc + 1;
        e.grant = '0;
        if (m_busy) e.grant[m_owner] = 1'b1;
        e.gv    = m_busy;
        e.idx   = m_busy ? IDXW'(m_owner) : '0;
        e.done  = m_done;
        e.werr  = m_werr;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    exp_t me;
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            me = expq.pop_front();
            n_checks++;
            if (grant === me.grant && grant_valid === me.gv && grant_idx === me.idx &&
                pkt_done === me.done && dut_werr === me.werr) begin
                n_pass++;
            end else begin
                $display("FAIL outputs cyc=%0d got grant=%b gv=%b idx=%0d done=%b werr=%b expected grant=%b gv=%b idx=%0d done=%b werr=%b",
                         cyc, grant, grant_valid, grant_idx, pkt_done, dut_werr,
                         me.grant, me.gv, me.idx, me.done, me.werr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [N-1:0] rq;
        logic         r;
        logic         bf;
        logic         bl;

        // Reset then idle
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        repeat (3) step(0, 4'b0000, 0, 0);

        // Single requester, 3-beat packet
        step(0, 4'b0100, 0, 0);
        step(0, 4'b0100, 1, 0);
        step(0, 4'b0100, 1, 0);
        step(0, 4'b0100, 1, 1);
        step(0, 4'b0000, 0, 0);

        // Round robin from a fresh pointer, single-beat packets
        step(1, 4'b0000, 0, 0);
        repeat (12) step(0, 4'b1111, 1, 1);
        step(0, 4'b0000, 0, 0);

        // Wrap and skip: ptr=3 then req=0011
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0100, 0, 0);
        step(0, 4'b0100, 1, 1);
        step(0, 4'b0011, 0, 0);
        step(0, 4'b0011, 1, 1);
        step(0, 4'b0011, 0, 0);
        step(0, 4'b0011, 1, 1);
        step(0, 4'b0000, 0, 0);

        // Hold across req drop, beats in IDLE ignored
        step(0, 4'b0010, 0, 0);
        step(0, 4'b0000, 1, 0);
        step(0, 4'b0000, 0, 1);
        step(0, 4'b0000, 1, 1);
        step(0, 4'b0000, 1, 1);
        step(0, 4'b0000, 1, 1);

        // Reset mid-packet
        step(0, 4'b1000, 0, 0);
        step(0, 4'b1000, 1, 0);
        step(1, 4'b1000, 1, 0);
        step(0, 4'b1111, 0, 0);
        step(0, 4'b0000, 1, 1);
        step(0, 4'b0000, 0, 0);

`ifdef XBAR_SCHED_WDOG_EN
        // Watchdog: no beats while busy, then sticky error until reset
        step(0, 4'b0001, 0, 0);
        repeat (12) step(0, 4'b0000, 0, 0);
        step(0, 4'b0010, 0, 0);
        repeat (6) step(0, 4'b0000, 0, 0);
        step(0, 4'b0000, 1, 1);
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 0);
`endif

        // Randomised traffic with periodic quiet stretches
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 249) == 0);
            rq = ($urandom_range(0, 3) == 0) ? 4'b0000 : N'($urandom);
            if ((i % 300) < 20) begin
                bf = 1'b0;
            end else begin
                bf = ($urandom_range(0, 1) == 1);
            end
            bl = ($urandom_range(0, 2) == 0);
            step(r, rq, bf, bl);
        end

        repeat (2) step(0, 4'b0000, 0, 0);
        @(negedge clk);
        #1;
        n_checks++;
        if (expq.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain got %0d pending expected 0 pending", expq.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
